// File: rtl/dbg_mailbox_responder_if.sv
// Debug-mailbox bus interface: a single-cycle write strobe with address and
// data, plus a combinational read-back of the addressed word.
//   we    : write strobe, one cycle per write
//   addr  : word index (0..7 args, 8 status, 9 pass_cnt, 10 fail_cnt)
//   wdata : write data
//   rdata : read data for addr
interface dbg_mailbox_responder_if;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output we, output addr, output wdata, input rdata);
    modport slave  (input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/dbg_mailbox_responder.sv
// Hardware responder for the debug-mailbox protocol. The CPU fills argument
// words 1..7 and then writes a command code to word 0. The block scoreboards
// assert-equal/not-equal results, latches halt, and prints up to four
// characters of argument word 1 on an 8N1 serial line.
// Ports:
//   clk       : system clock, rising edge
//   reset     : synchronous active-low reset
//   bus       : mailbox bus (slave side)
//   busy      : command executing
//   halted    : command 0 received, sticky until reset
//   fail_seen : an assert command failed, sticky
//   tx        : serial output, idle high
//
// state  | meaning
// IDLE   | waiting for a command write to word 0
// EXEC   | one-cycle dispatch on the command code
// LOAD   | pick byte k of the print word, or finish
// START  | start bit (tx low)
// DATA   | eight data bits, LSB first
// STOP   | stop bit (tx high), then advance to next byte
module dbg_mailbox_responder #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    dbg_mailbox_responder_if.slave   bus,
    output logic                     busy,
    output logic                     halted,
    output logic                     fail_seen,
    output logic                     tx
);
    localparam int CLK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CLK_W-1:0] BIT_LOAD = CLK_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_EXEC, S_LOAD, S_START, S_DATA, S_STOP
    } state_t;

    state_t            state, next_state;
    logic [31:0]       args [8];
    logic [31:0]       cmd_a1, cmd_a2;
    logic [CNT_W-1:0]  pass_cnt, fail_cnt;
    logic              overrun, unsupported;
    logic [2:0]        byte_idx;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;
    logic [CLK_W-1:0]  clk_cnt;
    logic              tmr_done, cmd_wr, cmd_accept, assert_pass;
    logic [7:0]        cur_byte;

    assign busy       = (state != S_IDLE);
    assign tmr_done   = (clk_cnt == '0);
    assign cmd_wr     = bus.we && (bus.addr == 4'd0);
    assign cmd_accept = cmd_wr && !busy && !halted;
    assign tx         = (state == S_START) ? 1'b0 :
                        (state == S_DATA)  ? shift[0] : 1'b1;

    always_comb begin
        cur_byte = 8'h00;
        case (byte_idx[1:0])
            2'd0: cur_byte = cmd_a1[7:0];
            2'd1: cur_byte = cmd_a1[15:8];
            2'd2: cur_byte = cmd_a1[23:16];
            2'd3: cur_byte = cmd_a1[31:24];
            default: cur_byte = 8'h00;
        endcase
    end

    // Command 2 is the inverse of command 1.
    assign assert_pass = (args[0] == 32'd1) ? (cmd_a1 == cmd_a2) : (cmd_a1 != cmd_a2);

    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (cmd_accept) next_state = S_EXEC;
            S_EXEC:  next_state = (args[0] == 32'd3) ? S_LOAD : S_IDLE;
            S_LOAD:  next_state = (byte_idx == 3'd4 || cur_byte == 8'h00) ? S_IDLE : S_START;
            S_START: if (tmr_done) next_state = S_DATA;
            S_DATA:  if (tmr_done && bit_idx == 3'd7) next_state = S_STOP;
            S_STOP:  if (tmr_done) next_state = S_LOAD;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) args[i] <= '0;
            cmd_a1      <= '0;
            cmd_a2      <= '0;
            pass_cnt    <= '0;
            fail_cnt    <= '0;
            halted      <= 1'b0;
            fail_seen   <= 1'b0;
            overrun     <= 1'b0;
            unsupported <= 1'b0;
            byte_idx    <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            clk_cnt     <= '0;
        end else begin
            if (bus.we && bus.addr[3] == 1'b0 && bus.addr[2:0] != 3'd0)
                args[bus.addr[2:0]] <= bus.wdata;

            if (cmd_accept) begin
                args[0] <= bus.wdata;
                cmd_a1  <= args[1];
                cmd_a2  <= args[2];
            end else if (cmd_wr && busy) begin
                overrun <= 1'b1;
            end

            // Bit timer reloads on every state change and on each data-bit boundary.
            if (state != next_state || (state == S_DATA && tmr_done))
                clk_cnt <= BIT_LOAD;
            else if (!tmr_done)
                clk_cnt <= clk_cnt - 1'b1;

            case (state)
                S_EXEC: begin
                    case (args[0])
                        32'd0: halted <= 1'b1;
                        32'd1, 32'd2: begin
                            if (assert_pass) begin
                                if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
                            end else begin
                                if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
                                fail_seen <= 1'b1;
                            end
                        end
                        32'd3: byte_idx <= '0;
                        32'h0001_0000, 32'hFFFF_0000: ;
                        default: unsupported <= 1'b1;
                    endcase
                end
                S_LOAD: begin
                    shift   <= cur_byte;
                    bit_idx <= '0;
                end
                S_DATA: begin
                    if (tmr_done && bit_idx != 3'd7) begin
                        shift   <= {1'b0, shift[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                    end
                end
                S_STOP: if (tmr_done) byte_idx <= byte_idx + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.rdata = 32'h0;
        case (bus.addr)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7:
                bus.rdata = args[bus.addr[2:0]];
            4'd8:  bus.rdata = {27'b0, unsupported, overrun, fail_seen, halted, busy};
            4'd9:  bus.rdata = 32'(pass_cnt);
            4'd10: bus.rdata = 32'(fail_cnt);
            default: bus.rdata = 32'h0;
        endcase
    end
endmodule

// File: tb/tb_dbg_mailbox_responder.sv
module tb_dbg_mailbox_responder;
    logic clk = 1'b0;
    logic reset;
    logic busy, halted, fail_seen, tx;
    int   vectors = 0;
    int   miscompares = 0;
    logic tx_log   [200];
    logic busy_log [200];
    logic [31:0] rv;

    dbg_mailbox_responder_if mb ();

    dbg_mailbox_responder #(.CLKS_PER_BIT(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .bus(mb.slave),
        .busy(busy), .halted(halted), .fail_seen(fail_seen), .tx(tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        mb.we = 1'b1; mb.addr = a; mb.wdata = d;
        @(posedge clk); #1;
        mb.we = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        mb.addr = a;
        #1 d = mb.rdata;
    endtask

    // Call right after a command write; returns cycles with busy high (bounded).
    task automatic busy_len(output int n);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
    endtask

    // Log tx/busy per cycle after a print write; optionally inject a cmd write at cycle ovr_at.
    task automatic log_print(input int ncyc, input int ovr_at);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            tx_log[i] = tx;
            busy_log[i] = busy;
            if (i == ovr_at) begin
                mb.we = 1'b1; mb.addr = 4'd0; mb.wdata = 32'd1;
            end else begin
                mb.we = 1'b0;
            end
        end
        mb.we = 1'b0;
    endtask

    // Byte j of a print: LOAD at cycle 1+41j, start 4 cycles, 8 bits x4, stop 4.
    task automatic chk_frame(input int j, input logic [7:0] b);
        int base;
        base = 1 + 41 * j;
        chk($sformatf("start%0d", j), 32'(tx_log[base + 3]), 32'd0);
        for (int k = 0; k < 8; k++)
            chk($sformatf("byte%0d_bit%0d", j, k), 32'(tx_log[base + 7 + 4 * k]), 32'(b[k]));
        chk($sformatf("stop%0d", j), 32'(tx_log[base + 39]), 32'd1);
    endtask

    int n;

    initial begin
        mb.we = 1'b0; mb.addr = 4'd0; mb.wdata = 32'h0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        rd(4'd8, rv);  chk("reset_status", rv, 32'h0);
        chk("reset_tx", 32'(tx), 32'd1);
        rd(4'd9, rv);  chk("reset_pass", rv, 32'h0);
        rd(4'd10, rv); chk("reset_fail", rv, 32'h0);

        wr(4'd1, 32'h1234);
        wr(4'd2, 32'h1234);
        rd(4'd1, rv); chk("arg1_read", rv, 32'h1234);
        wr(4'd0, 32'd1);
        busy_len(n); chk("eq_busy_len", 32'(n), 32'd1);
        rd(4'd9, rv);  chk("eq_pass", rv, 32'd1);

        wr(4'd2, 32'h1235);
        wr(4'd0, 32'd1);
        busy_len(n); chk("neq_busy_len", 32'(n), 32'd1);
        rd(4'd10, rv); chk("neq_fail", rv, 32'd1);
        chk("fail_seen", 32'(fail_seen), 32'd1);
        rd(4'd8, rv);  chk("status_fail", rv, 32'h4);

        wr(4'd0, 32'd2);
        busy_len(n); chk("ne_busy_len", 32'(n), 32'd1);
        rd(4'd9, rv);  chk("ne_pass", rv, 32'd2);

        wr(4'd0, 32'h0001_0000);
        busy_len(n); chk("noop_busy_len", 32'(n), 32'd1);
        rd(4'd8, rv);  chk("noop_status", rv, 32'h4);
        wr(4'd12, 32'hDEAD);
        rd(4'd12, rv); chk("addr12_zero", rv, 32'h0);

        // Print "Hi" with a command write dropped mid-frame.
        wr(4'd1, 32'h0000_6948);
        wr(4'd0, 32'd3);
        log_print(100, 20);
        n = 0;
        for (int i = 0; i < 100; i++) if (busy_log[i]) n++;
        chk("print_busy_len", 32'(n), 32'd84);
        chk("print_busy_last", 32'(busy_log[83]), 32'd1);
        chk("print_busy_end", 32'(busy_log[84]), 32'd0);
        chk_frame(0, 8'h48);
        chk_frame(1, 8'h69);
        n = 0;
        for (int i = 84; i < 100; i++) if (!tx_log[i]) n++;
        chk("no_third_frame", 32'(n), 32'd0);
        rd(4'd8, rv);  chk("overrun_status", rv, 32'hC);
        rd(4'd9, rv);  chk("ovr_pass", rv, 32'd2);
        rd(4'd10, rv); chk("ovr_fail", rv, 32'd1);

        wr(4'd0, 32'd7);
        busy_len(n);
        rd(4'd8, rv);  chk("unsupported_status", rv, 32'h1C);

        // Reset during a data bit aborts the frame.
        wr(4'd1, 32'h0000_0041);
        wr(4'd0, 32'd3);
        repeat (15) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        rd(4'd8, rv);  chk("rst_status", rv, 32'h0);

        wr(4'd1, 32'h0000_0041);
        wr(4'd0, 32'd3);
        log_print(60, -1);
        n = 0;
        for (int i = 0; i < 60; i++) if (busy_log[i]) n++;
        chk("reprint_busy_len", 32'(n), 32'd43);
        chk_frame(0, 8'h41);

        // Halt, then commands are ignored.
        wr(4'd0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("halted", 32'(halted), 32'd1);
        wr(4'd2, 32'h0000_0041);
        wr(4'd0, 32'd1);
        @(negedge clk);
        chk("halt_busy", 32'(busy), 32'd0);
        rd(4'd9, rv);  chk("halt_pass", rv, 32'd0);
        rd(4'd8, rv);  chk("halt_status", rv, 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end
endmodule

// File: doc/dbg_mailbox_responder.md
Name: dbg_mailbox_responder

Overview:
- Synthesizable responder for the debug-mailbox protocol the core drives with `sw` to the debug RAM.
- The CPU fills argument words 1..7, then writes the command code to word 0 (the function register).
- The block decodes the command in hardware: assert-equal/not-equal scoreboarding, halt, and 4-character print over an 8N1 serial TX line.
- Sits in `unit_memory` beside the debug RAM address window, so silicon/FPGA runs report results without the simulation bench.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit (minimum 2)
CNT_W, 16, width of pass/fail counters

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-low (0 = reset)
we  in  1  bus write strobe, one cycle per write
addr  in  4  word index: 0..7 argument words, 8 status, 9 pass_cnt, 10 fail_cnt
wdata  in  32  write data
rdata  out  32  combinational read of addressed word; 0 for addr 11..15
busy  out  1  command executing
halted  out  1  command 0 received; sticky until reset
fail_seen  out  1  any assert failed; sticky
tx  out  1  serial output, idle high

Behaviour:
- Reset (reset==0 at rising edge) values:
  - args[0..7]=0, pass_cnt=fail_cnt=0, busy=0, halted=0, fail_seen=0, overrun=0, unsupported=0, tx=1, FSM=IDLE.
  - Reset mid-transmission aborts the frame; tx returns to 1 on the next edge.
- Writes to addr 1..7 always update args[addr], including while busy. Writes to addr 8..15 are ignored.
- Write to addr 0:
  - In IDLE and not halted: args[0]<=wdata; snapshot args[1], args[2] into cmd regs; FSM->EXEC; busy=1 from the next cycle.
  - While busy: write dropped, overrun<=1.
  - While halted: write dropped, no flag.
- EXEC executes in one cycle, dispatching on args[0]:
  - 0: halted<=1 -> IDLE.
  - 1: if a1==a2, pass_cnt++, else fail_cnt++ and fail_seen<=1 -> IDLE.
  - 2: inverse of 1 (pass if a1!=a2) -> IDLE.
  - 3: byte index k=0 -> LOAD.
  - 32'h0001_0000, 32'hFFFF_0000: no-op (bench-only checks) -> IDLE.
  - other: unsupported<=1 -> IDLE.
- Counters saturate at all-ones (no wrap).
- Print path:
  - LOAD: byte=a1[8k+:8]. If byte==0 or k==4 -> IDLE (busy drops); else -> START.
  - START: tx=0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles -> STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles; k++ -> LOAD.
- Timing:
  - Write->busy: busy rises the cycle after the we edge.
  - Non-print command: busy high exactly 1 cycle.
  - Print of n bytes: busy high 1 + n*(10*CLKS_PER_BIT+1) + 1 cycles.
- Status word (addr 8): {27'b0, unsupported, overrun, fail_seen, halted, busy}.
- Simultaneous write to addr 0 in the same cycle busy drops: treated as busy -> dropped + overrun. Software must poll busy==0 before issuing the next command.

Test Plan:
- Reset held 3 cycles, then released -> rdata@8=0, tx=1, pass_cnt=fail_cnt=0.
- Write args1=0x1234, args2=0x1234, then addr0=1; repeat with args2=0x1235 -> pass_cnt=1, fail_cnt=1, fail_seen=1, busy high 1 cycle each.
- CLKS_PER_BIT=4: args1=0x00006948 ("Hi"), addr0=3 -> tx frames 0x48 then 0x69, each start low 4 clk, LSB-first data, stop high 4 clk; busy high 1+2*41+1=84 cycles; no third frame.
- During that print, write addr0=1 -> dropped, overrun=1 (status bit 3), counters unchanged.
- Write addr0=0 -> halted=1 next cycle; subsequent addr0=1 write ignored, pass_cnt unchanged; addr0=0x7 on a fresh run -> unsupported=1.
- Assert reset during the DATA bit of a print -> next edge tx=1, busy=0, FSM IDLE; a new print after release transmits correctly.
